// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and size/legality helpers for the load/store unit.
package lsu_pkg;

   localparam int LSU_LOAD   = 4;
   localparam int LSU_STORE  = 3;
   localparam int LSU_F3_MSB = 2;
   localparam int LSU_F3_LSB = 0;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC0 = 2'd1,
      S_ACC1 = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

   function automatic logic [2:0] lsu_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   lsu_size = 3'd1;
         2'b01:   lsu_size = 3'd2;
         default: lsu_size = 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] lsu_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   lsu_mask = 4'b0001;
         2'b01:   lsu_mask = 4'b0011;
         default: lsu_mask = 4'b1111;
      endcase
   endfunction

   // Only meaningful when exactly one of is_load/is_store is set.
   function automatic logic lsu_legal(input logic [4:0] lsunit);
      logic [2:0] f3;
      f3 = lsunit[LSU_F3_MSB:LSU_F3_LSB];
      if (lsunit[LSU_LOAD] && !lsunit[LSU_STORE])
         lsu_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU);
      else if (lsunit[LSU_STORE] && !lsunit[LSU_LOAD])
         lsu_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         lsu_legal = 1'b0;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads,
// kept free of state so a cached LSU can reuse it.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata0,
   input  logic [31:0] i_rdata1,
   output logic [7:0]  o_be64,
   output logic [63:0] o_wd64,
   output logic [31:0] o_ldata
);

   logic [63:0] w_shift;

   assign o_be64  = {4'b0000, lsu_mask(i_funct3)} << i_off;
   assign o_wd64  = {32'h0, i_wdata} << {i_off, 3'b000};
   assign w_shift = {i_rdata1, i_rdata0} >> {i_off, 3'b000};

   always_comb begin
      o_ldata = w_shift[31:0];
      case (i_funct3)
         F3_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_BU:   o_ldata = {24'h0, w_shift[7:0]};
         F3_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_HU:   o_ldata = {16'h0, w_shift[15:0]};
         default: o_ldata = w_shift[31:0];
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one decoded access at a time and runs it as one or two
// word beats on a handshaked memory bus, returning a registered response pulse.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  lsunit,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  r_state, w_next;
   logic [4:0]  r_lsunit;
   logic [31:0] r_addr, r_wdata, r_rbuf0, r_resp_rdata;
   logic        r_resp_err;

   logic        w_in_noop, w_in_split, w_in_err, w_accept, w_split;
   logic [31:0] w_word0, w_word1, w_rb0, w_rb1, w_ldata;
   logic [7:0]  w_be64;
   logic [63:0] w_wd64;

   assign w_accept   = req_valid && (r_state == S_IDLE);
   assign w_in_noop  = !lsunit[LSU_LOAD] && !lsunit[LSU_STORE];
   assign w_in_split = ({1'b0, addr[1:0]} + lsu_size(lsunit[LSU_F3_MSB:LSU_F3_LSB])) > 3'd4;
   assign w_in_err   = !w_in_noop &&
                       (!lsu_legal(lsunit) || (!ALLOW_MISALIGNED && w_in_split));

   assign w_split = ({1'b0, r_addr[1:0]} + lsu_size(r_lsunit[LSU_F3_MSB:LSU_F3_LSB])) > 3'd4;
   assign w_word0 = {r_addr[31:2], 2'b00};
   assign w_word1 = w_word0 + 32'd4;

   // The final beat's read word is consumed straight off the bus so the response
   // can be registered on the same edge as the ack.
   assign w_rb0 = (r_state == S_ACC0) ? mem_rdata : r_rbuf0;
   assign w_rb1 = (r_state == S_ACC1) ? mem_rdata : 32'h0;

   lsu_align u_align (
      .i_off    (r_addr[1:0]),
      .i_funct3 (r_lsunit[LSU_F3_MSB:LSU_F3_LSB]),
      .i_wdata  (r_wdata),
      .i_rdata0 (w_rb0),
      .i_rdata1 (w_rb1),
      .o_be64   (w_be64),
      .o_wd64   (w_wd64),
      .o_ldata  (w_ldata)
   );

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_be    = 4'h0;
      mem_wdata = 32'h0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               w_next = (w_in_err || w_in_noop) ? S_RESP : S_ACC0;
         end
         S_ACC0: begin
            mem_req   = 1'b1;
            mem_we    = r_lsunit[LSU_STORE];
            mem_addr  = w_word0;
            mem_be    = w_be64[3:0];
            mem_wdata = w_wd64[31:0];
            if (mem_ack)
               w_next = w_split ? S_ACC1 : S_RESP;
         end
         S_ACC1: begin
            mem_req   = 1'b1;
            mem_we    = r_lsunit[LSU_STORE];
            mem_addr  = w_word1;
            mem_be    = w_be64[7:4];
            mem_wdata = w_wd64[63:32];
            if (mem_ack)
               w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lsunit <= 5'h0;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_rbuf0  <= 32'h0;
      end else begin
         if (w_accept) begin
            r_lsunit <= lsunit;
            r_addr   <= addr;
            r_wdata  <= wdata;
         end
         if (r_state == S_ACC0 && mem_ack)
            r_rbuf0 <= mem_rdata;
      end
   end

   // Response registers are loaded only on the edge entering RESP, so they read 0 elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_err   <= w_accept && w_in_err;
         r_resp_rdata <= (w_next == S_RESP && r_state != S_IDLE && r_lsunit[LSU_LOAD])
                         ? w_ldata : 32'h0;
      end
   end

   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Sequential load/store unit sitting between the core datapath and data memory. It consumes the 5-bit `lsunit` load/store control word produced by instruction decode, together with the effective address and store data. It then drives a word-wide handshaked memory bus. Misaligned accesses are split into two word beats, and load results are returned with byte/half extraction and sign or zero extension applied.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 splits word-crossing accesses into two beats; 0 reports them as errors with no memory access.
- `clk` in 1: the single clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the core presents an access.
- `req_ready` out 1: the unit accepts an access; high only in IDLE.
- `lsunit` in 5: `{is_load, is_store, funct3}`.
- `addr` in 32: byte effective address.
- `wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: illegal encoding, or misaligned access with `ALLOW_MISALIGNED`=0.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: write beat.
- `mem_addr` out 32: word-aligned address; bits [1:0] are always 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-steered write data.
- `mem_ack` in 1: beat complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
- **Legal encodings:**
  - Loads (`is_load`=1, `is_store`=0): `funct3` 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores (`is_load`=0, `is_store`=1): `funct3` 000 SB, 001 SH, 010 SW.
- **Illegal encodings:** any other `funct3`, or `is_load`=`is_store`=1. These go IDLE->RESP with `resp_err`=1 and issue no `mem_req`.
- **Neither flag set:** a request with `is_load`=`is_store`=0 completes IDLE->RESP as a no-op, `resp_err`=0.
- **Request latching:** on `req_valid`&&`req_ready`, the unit latches `lsunit`, `addr`, `wdata` and computes:
  - `off`=`addr[1:0]`.
  - `size` = 1/2/4 bytes.
  - `mask` = 4'b0001/0011/1111.
  - `split` = (`off`+`size`>4).
- **Lane steering:**
  - `be64` = `mask` << `off`.
  - `wd64` = {32'b0, `wdata`} << (8*`off`).
  - Beat0 uses the word at `addr` & ~3 with `be64[3:0]` and `wd64[31:0]`.
  - Beat1 uses the word at (`addr` & ~3)+4 (32-bit wrap; 0xFFFFFFFC wraps to 0x00000000) with `be64[7:4]` and `wd64[63:32]`.
- **Load assembly:** {beat1 rdata, beat0 rdata} >> (8*`off`), take the low `size` bytes, then sign-extend (LB/LH) or zero-extend.
- **Single-beat loads:** beat1 rdata is treated as 0.
- **States:**
  - IDLE: `req_ready`=1. Accept goes to ACC0, or to RESP when illegal/no-op/rejected-misaligned.
  - ACC0: `mem_req`=1 with beat0 fields. On `mem_ack`, go to ACC1 if `split`, else RESP. Capture `mem_rdata` into rbuf0.
  - ACC1: `mem_req`=1 with beat1 fields. On `mem_ack`, go to RESP. Capture rbuf1.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- **Request stability:** `mem_*` fields stay stable while `mem_req`=1 until `mem_ack`. `mem_req` drops in the cycle after the final ack.
- **Ignored `mem_ack`:** ignored in IDLE and RESP.
- **Reset:** asynchronous; immediately returns the unit to IDLE. A pending `mem_ack` for an aborted beat is ignored. A split store aborted after beat0 leaves beat0 written; that is a documented hazard.

## Timing
- **Reset values:**
  - `req_ready`=1.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- **Zero-wait memory** (`mem_ack` in the same cycle as `mem_req`), with accept at cycle 0:
  - Single beat: `mem_req` in cycle 1, `resp_valid` in cycle 2.
  - Split: beats in cycles 1–2, `resp_valid` in cycle 3.
  - Error/no-op: `resp_valid` in cycle 1.
- **Wait states:** each wait cycle on `mem_ack` adds one cycle.
- **Throughput:** `req_ready` returns in the cycle after `resp_valid`. There is no overlap of requests.
- **Response outputs:** `resp_rdata` and `resp_err` are registered and valid only while `resp_valid`=1. They hold 0 otherwise.

## Structure
- **Package `lsu_pkg`:**
  - `lsunit` bit positions (`LSU_LOAD`=4, `LSU_STORE`=3, `LSU_F3`=[2:0]).
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State encoding (`S_IDLE`, `S_ACC0`, `S_ACC1`, `S_RESP`).
- **Sub-module `lsu_align`:** combinational; owns `be64`/`wd64` generation and load extraction/extension. It is shared with any future cached LSU. The FSM and registers stay in `lsu_mem_ctrl`.

## Test plan
- **SW aligned:** SW `addr`=0x100, `wdata`=0xDEADBEEF, zero-wait -> one beat: `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF; `resp_valid` 2 cycles after accept, `resp_err`=0.
- **LB and LBU at offset 3:** memory word 0x80FF7F01 at 0x200.
  - LB `addr`=0x203 -> `resp_rdata`=0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH at 0x200 -> 0x00007F01.
- **Misaligned LW, two beats:** LW `addr`=0x302, words 0x302=0x44332211 (at 0x300) and 0x55667788 (at 0x304) -> beats 0x300 then 0x304; `resp_rdata`=0x77884433; 3 cycles with zero-wait.
- **Misaligned SH:** SH `addr`=0x7, `wdata`=0xABCD -> beat0 `mem_be`=1000, `mem_wdata`=0xCD000000; beat1 `mem_be`=0001, `mem_wdata`=0x000000AB, `mem_addr`=0x8. With `ALLOW_MISALIGNED`=0, the same request gives `resp_err`=1 and no `mem_req`.
- **Illegal encoding:** `lsunit`=5'b11010 -> `resp_err`=1, `mem_req` never asserted, `resp_valid` 1 cycle after accept.
- **Wait states and reset abort:** LW with `mem_ack` delayed 3 cycles -> `mem_*` stable throughout, `resp_valid` at cycle 5. A second LW, with `rst_n` pulsed low during ACC0 -> `mem_req`=0 immediately, a subsequent `mem_ack` is ignored, and `req_ready`=1.
